// File: rtl/centroid_updater.sv
// k-means centroid update: per-core point accumulation, then a sequential
// pass that divides each enabled core's sums by its count.

module centroid_acc #(
    parameter int COORD_W = 10,
    parameter int COUNT_W = 12,
    parameter int SUM_W   = COORD_W + COUNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    input  logic [COORD_W-1:0] pt_x,
    input  logic [COORD_W-1:0] pt_y,
    output logic [SUM_W-1:0]   sum_x,
    output logic [SUM_W-1:0]   sum_y,
    output logic [COUNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sum_x <= '0;
            sum_y <= '0;
            count <= '0;
        end else if (inc) begin
            sum_x <= sum_x + SUM_W'(pt_x);
            sum_y <= sum_y + SUM_W'(pt_y);
            count <= count + COUNT_W'(1);
        end
    end

endmodule

module centroid_updater #(
    parameter int NCORE   = 16,
    parameter int COORD_W = 10,
    parameter int COUNT_W = 12,
    parameter int SUM_W   = COORD_W + COUNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pt_valid,
    output logic               pt_ready,
    input  logic [COORD_W-1:0] pt_x,
    input  logic [COORD_W-1:0] pt_y,
    input  logic [NCORE-1:0]   closest_core,
    input  logic [NCORE-1:0]   en,
    input  logic               update_start,
    output logic               busy,
    output logic               cent_valid,
    output logic [3:0]         cent_idx,
    output logic [COORD_W-1:0] cent_x,
    output logic [COORD_W-1:0] cent_y,
    output logic               done,
    output logic               sel_err,
    output logic               overflow
);

    localparam int IDX_W  = $clog2(NCORE);
    localparam int STEP_W = $clog2(SUM_W + 1);

    typedef enum logic {ACCUM, DIVIDE} state_t;

    state_t state_q, state_d;

    logic [NCORE-1:0][SUM_W-1:0]   sum_x, sum_y;
    logic [NCORE-1:0][COUNT_W-1:0] count;
    logic [NCORE-1:0]              inc;

    logic [IDX_W-1:0]   sel_k, cur;
    logic               sel_any, sat, acc_ok;
    logic [STEP_W-1:0]  step;
    logic               slot_active, slot_end, last;

    logic [SUM_W-1:0]   dx, dy, src_x, src_y;
    logic [COUNT_W-1:0] rx, ry, src_rx, src_ry;
    logic [COUNT_W+SUM_W-1:0] nx, ny;

    // One restoring-division iteration: shift the dividend MSB into the
    // remainder and the quotient bit into the dividend's LSB.
    function automatic logic [COUNT_W+SUM_W-1:0] div_step(
        input logic [COUNT_W-1:0] r,
        input logic [SUM_W-1:0]   d,
        input logic [COUNT_W-1:0] dv
    );
        logic [COUNT_W:0] t;
        logic             q;
        t = {r, d[SUM_W-1]};
        q = 1'b0;
        if (t >= {1'b0, dv}) begin
            t = t - {1'b0, dv};
            q = 1'b1;
        end
        return {t[COUNT_W-1:0], d[SUM_W-2:0], q};
    endfunction

    // Lowest set bit of closest_core wins.
    always_comb begin
        sel_k = '0;
        for (int i = NCORE - 1; i >= 0; i--) begin
            if (closest_core[i]) sel_k = IDX_W'(i);
        end
    end

    assign sel_any = |closest_core;
    assign sat     = &count[sel_k];
    assign acc_ok  = (state_q == ACCUM) && pt_valid && sel_any && !sat;

    genvar g;
    generate
        for (g = 0; g < NCORE; g++) begin : g_core
            assign inc[g] = acc_ok && (sel_k == IDX_W'(g));
            centroid_acc #(
                .COORD_W(COORD_W),
                .COUNT_W(COUNT_W),
                .SUM_W  (SUM_W)
            ) u_acc (
                .clk  (clk),
                .rst  (rst),
                .clr  (last),
                .inc  (inc[g]),
                .pt_x (pt_x),
                .pt_y (pt_y),
                .sum_x(sum_x[g]),
                .sum_y(sum_y[g]),
                .count(count[g])
            );
        end
    endgenerate

    // Step 0 feeds the first iteration straight from the core's sums so the
    // quotient lands after step SUM_W-1 and cent_valid fills the last slot cycle.
    always_comb begin
        src_x  = (step == '0) ? sum_x[cur] : dx;
        src_y  = (step == '0) ? sum_y[cur] : dy;
        src_rx = (step == '0) ? '0 : rx;
        src_ry = (step == '0) ? '0 : ry;
        nx     = div_step(src_rx, src_x, count[cur]);
        ny     = div_step(src_ry, src_y, count[cur]);
    end

    always_comb begin
        state_d     = state_q;
        slot_active = en[cur] && (count[cur] != '0);
        slot_end    = ((step == '0) && !slot_active) || (step == STEP_W'(SUM_W));
        last        = (state_q == DIVIDE) && slot_end && (cur == IDX_W'(NCORE - 1));
        case (state_q)
            ACCUM:   if (update_start) state_d = DIVIDE;
            DIVIDE:  if (last)         state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ACCUM;
        else     state_q <= state_d;
    end

    assign pt_ready = (state_q == ACCUM);
    assign busy     = (state_q == DIVIDE);

    always_ff @(posedge clk) begin
        if (rst) begin
            step       <= '0;
            cur        <= '0;
            dx         <= '0;
            dy         <= '0;
            rx         <= '0;
            ry         <= '0;
            cent_valid <= 1'b0;
            cent_idx   <= '0;
            cent_x     <= '0;
            cent_y     <= '0;
            done       <= 1'b0;
            sel_err    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            cent_valid <= 1'b0;
            done       <= last;
            if (state_q == ACCUM) begin
                if (pt_valid && !sel_any)  sel_err  <= 1'b1;
                else if (pt_valid && sat)  overflow <= 1'b1;
                if (update_start) begin
                    cur  <= '0;
                    step <= '0;
                end
            end else if (slot_end) begin
                step <= '0;
                cur  <= cur + IDX_W'(1);
            end else begin
                {rx, dx} <= nx;
                {ry, dy} <= ny;
                step     <= step + STEP_W'(1);
                if (step == STEP_W'(SUM_W - 1)) begin
                    cent_valid <= 1'b1;
                    cent_idx   <= 4'(cur);
                    cent_x     <= nx[COORD_W-1:0];
                    cent_y     <= ny[COORD_W-1:0];
                end
            end
        end
    end

endmodule
